aes_trace_sequencer: RTL and testbench
======================================

# aes_trace_sequencer

Parametrised encryption-campaign driver that sits in front of `AES_top` and replaces hand-timed stimulus. It feeds `AES_top` a programmable number of encryptions under one key, generating each plaintext as fixed, incrementing, pseudo-random, or fixed-vs-random interleaved. It holds `AES_en` per encryption until `AES_data_out_valid`, returns each ciphertext with its plaintext, inserts programmable idle gaps between encryptions, and flags a stalled core with a timeout.

## Interface
Parameters:
- DATA_W, 128, data/key width; must be a multiple of 32
- CNT_W, 16, width of trace counters
- GAP_W, 8, width of inter-encryption gap count
- TIMEOUT, 64, max cycles `AES_en` stays high awaiting valid (≥2)
- LFSR_SEED, 32'hACE1_2468, LFSR reset/start value; must be nonzero

Ports:
- AES_clk  in  1  clock; all logic rising-edge
- AES_rst_n  in  1  asynchronous active-low reset
- start  in  1  begin campaign (sampled in IDLE only)
- abort  in  1  stop campaign immediately
- mode  in  2  00 fixed, 01 increment, 10 random, 11 fixed/random alternate
- base_pt  in  DATA_W  base plaintext
- key  in  DATA_W  campaign key
- trace_count  in  CNT_W  encryptions to run
- gap_cycles  in  GAP_W  idle cycles between encryptions
- AES_en  out  1  enable to AES_top
- AES_data_in  out  DATA_W  plaintext to AES_top
- AES_key_in  out  DATA_W  key to AES_top
- AES_data_out_valid  in  1  AES_top result valid
- AES_data_out  in  DATA_W  AES_top ciphertext
- ct_valid  out  1  one-cycle pulse, ct_out/pt_out valid
- ct_out  out  DATA_W  captured ciphertext
- pt_out  out  DATA_W  plaintext that produced ct_out
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at campaign end
- timeout_err  out  1  sticky; cleared by next accepted start
- traces_done  out  CNT_W  completed encryptions this campaign

## Operation
- FSM states: IDLE, LOAD, RUN, GAP, DONE.
- IDLE: on start, latch mode, base_pt, key, trace_count, gap_cycles; clear traces_done, timeout_err, index; reload LFSR with LFSR_SEED; go to LOAD. If trace_count==0, go directly to DONE.
- LOAD (1 cycle): compute plaintext for the current index into AES_data_in; AES_key_in = latched key; go to RUN.
- RUN: AES_en=1, data/key held stable. When AES_data_out_valid is seen:
  - capture AES_data_out into ct_out and AES_data_in into pt_out;
  - pulse ct_valid next cycle;
  - traces_done++, index++;
  - AES_en drops next cycle.
  - Then: if traces_done reaches trace_count, go to DONE; else if gap_cycles==0, go to LOAD; else go to GAP.
- RUN timeout: TIMEOUT cycles without valid sets timeout_err, drops AES_en, and goes to DONE. The trace is not counted.
- GAP: count gap_cycles cycles with AES_en=0, then go to LOAD.
- DONE: pulse done for 1 cycle, then go to IDLE.
- abort (any non-IDLE state): go to IDLE next cycle; AES_en=0; no done pulse; traces_done holds.
- Plaintext generation:
  - 00: base_pt.
  - 01: base_pt + index, full DATA_W add, wraps mod 2^DATA_W.
  - 10: base_pt XOR {DATA_W/32 copies of LFSR}.
  - 11: base_pt when index is even, random as in 10 when odd.
- LFSR: 32-bit Galois, taps 32'h8020_0003, right-shift. Advances exactly once per LOAD that uses it (modes 10, and 11 on odd index).
- AES_data_out_valid outside RUN is ignored.
- start while busy is ignored.
- traces_done saturates at all-ones.

## Timing
- Reset values: AES_en=0, AES_data_in=0, AES_key_in=0, ct_valid=0, ct_out=0, pt_out=0, busy=0, done=0, timeout_err=0, traces_done=0, LFSR=LFSR_SEED, state IDLE.
- start at edge N: busy=1 at N+1 (LOAD), AES_en=1 at N+2.
- Valid sampled at edge V: ct_valid, ct_out, pt_out and the traces_done update all appear at V+1. AES_en=0 at V+1.
- Next AES_en rise: V+2+gap_cycles.
- Period per encryption: core latency + 2 + gap_cycles.
- Final trace: done pulses at V+2; busy falls at V+3.
- Timeout: AES_en high for exactly TIMEOUT cycles.
- abort and valid in the same cycle: abort wins; no capture, no count.
- Asynchronous reset mid-campaign forces all outputs to reset values immediately.

## Test plan
- Reset: assert AES_rst_n=0 mid-RUN. All outputs 0 asynchronously; AES_en=0 before the next edge.
- Mode 00: key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, base_pt 00000056_00000000_00000000_00000000, trace_count 3, gap 5, behavioural core with 51-cycle latency. Expect 3 ct_valid pulses, pt_out constant, encryption period 58 cycles, done once, traces_done=3.
- Mode 01: base_pt all-ones, trace_count 2. Expect pt_out sequence FF..FF then 00..00 (wrap).
- Mode 11 with gap 0: trace_count 4. Expect even traces pt=base_pt, odd traces pt=base_pt^replicate(LFSR). LFSR advances twice from LFSR_SEED. Back-to-back LOAD with no gap.
- Timeout: core never asserts valid, TIMEOUT=64. Expect AES_en high 64 cycles, timeout_err=1, done pulse, traces_done=0. A second start clears timeout_err.
- Abort/corner cases:
  - abort during GAP: returns to IDLE, no done pulse.
  - trace_count=0: done pulses without AES_en ever rising.
  - start while busy: ignored.

Source files
------------

// File: rtl/aes_trace_sequencer.sv
// aes_trace_sequencer: runs a campaign of encryptions on AES_top under one key,
// generating each plaintext, holding AES_en until the core answers, returning
// ciphertext/plaintext pairs and flagging a core that never answers.
module aes_trace_sequencer #(
    parameter int          DATA_W    = 128,
    parameter int          CNT_W     = 16,
    parameter int          GAP_W     = 8,
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic              AES_clk,
    input  logic              AES_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] base_pt,
    input  logic [DATA_W-1:0] key,
    input  logic [CNT_W-1:0]  trace_count,
    input  logic [GAP_W-1:0]  gap_cycles,
    output logic              AES_en,
    output logic [DATA_W-1:0] AES_data_in,
    output logic [DATA_W-1:0] AES_key_in,
    input  logic              AES_data_out_valid,
    input  logic [DATA_W-1:0] AES_data_out,
    output logic              ct_valid,
    output logic [DATA_W-1:0] ct_out,
    output logic [DATA_W-1:0] pt_out,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  traces_done
);
    localparam int               TMO_W     = $clog2(TIMEOUT + 1);
    localparam int               NWORDS    = DATA_W / 32;
    localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;

    // Campaign settings latched at an accepted start
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_base;
    logic [DATA_W-1:0] r_key;
    logic [CNT_W-1:0]  r_count;
    logic [GAP_W-1:0]  r_gap;

    logic [CNT_W-1:0]  r_index;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [31:0]       r_lfsr;
    logic [DATA_W-1:0] r_data_in;
    logic              r_ct_valid;
    logic [DATA_W-1:0] r_ct_out;
    logic [DATA_W-1:0] r_pt_out;
    logic              r_done;
    logic              r_timeout_err;
    logic [CNT_W-1:0]  r_traces;

    logic              w_busy;
    logic              w_start_ok;
    logic              w_valid_hit;
    logic              w_timeout_hit;
    logic [CNT_W-1:0]  w_traces_inc;
    logic              w_last;
    logic [31:0]       w_lfsr_next;
    logic              w_lfsr_use;
    logic [DATA_W-1:0] w_pt;

    // busy stays up through the done pulse so a start cannot overlap it
    assign w_busy        = (r_state != S_IDLE) || r_done;
    assign w_start_ok    = start && !w_busy;
    assign w_valid_hit   = (r_state == S_RUN) && AES_data_out_valid && !abort;
    assign w_timeout_hit = (r_state == S_RUN) && !AES_data_out_valid && !abort
                           && (r_tmo_cnt == TMO_LAST);
    assign w_traces_inc  = (r_traces == {CNT_W{1'b1}}) ? r_traces : r_traces + 1'b1;
    assign w_last        = (w_traces_inc == r_count);
    assign w_lfsr_next   = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);

    // Plaintext for the current index and whether it consumes an LFSR step
    always_comb begin
        w_pt       = r_base;
        w_lfsr_use = 1'b0;
        case (r_mode)
            2'b01:   w_pt = r_base + DATA_W'(r_index);
            2'b10: begin
                w_pt       = r_base ^ {NWORDS{r_lfsr}};
                w_lfsr_use = 1'b1;
            end
            2'b11: begin
                if (r_index[0]) begin
                    w_pt       = r_base ^ {NWORDS{r_lfsr}};
                    w_lfsr_use = 1'b1;
                end
            end
            default: w_pt = r_base;
        endcase
    end

    // State register
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    // Next-state decode and enable to the core
    always_comb begin
        w_state_next = r_state;
        AES_en       = 1'b0;
        if (r_state != S_IDLE && abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok)
                        w_state_next = (trace_count == '0) ? S_DONE : S_LOAD;
                end
                S_LOAD: w_state_next = S_RUN;
                S_RUN: begin
                    AES_en = 1'b1;
                    if (w_valid_hit) begin
                        if (w_last)            w_state_next = S_DONE;
                        else if (r_gap == '0)  w_state_next = S_LOAD;
                        else                   w_state_next = S_GAP;
                    end else if (w_timeout_hit) begin
                        w_state_next = S_DONE;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == r_gap - 1'b1) w_state_next = S_LOAD;
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Latch campaign settings on an accepted start
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_mode  <= '0;
            r_base  <= '0;
            r_key   <= '0;
            r_count <= '0;
            r_gap   <= '0;
        end else if (w_start_ok) begin
            r_mode  <= mode;
            r_base  <= base_pt;
            r_key   <= key;
            r_count <= trace_count;
            r_gap   <= gap_cycles;
        end
    end

    // Gap and timeout counters run only while in their own state
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_gap_cnt <= '0;
            r_tmo_cnt <= '0;
        end else begin
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
            r_tmo_cnt <= (r_state == S_RUN) ? r_tmo_cnt + 1'b1 : '0;
        end
    end

    // Trace index, completed count, sticky timeout flag and LFSR
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_index       <= '0;
            r_traces      <= '0;
            r_timeout_err <= 1'b0;
            r_lfsr        <= LFSR_SEED;
        end else if (w_start_ok) begin
            r_index       <= '0;
            r_traces      <= '0;
            r_timeout_err <= 1'b0;
            r_lfsr        <= LFSR_SEED;
        end else begin
            if (w_valid_hit) begin
                r_index  <= r_index + 1'b1;
                r_traces <= w_traces_inc;
            end
            if (w_timeout_hit)
                r_timeout_err <= 1'b1;
            if (r_state == S_LOAD && !abort && w_lfsr_use)
                r_lfsr <= w_lfsr_next;
        end
    end

    // Present plaintext to the core during LOAD; capture results on valid
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_data_in  <= '0;
            r_ct_valid <= 1'b0;
            r_ct_out   <= '0;
            r_pt_out   <= '0;
            r_done     <= 1'b0;
        end else begin
            if (r_state == S_LOAD && !abort)
                r_data_in <= w_pt;
            r_ct_valid <= w_valid_hit;
            if (w_valid_hit) begin
                r_ct_out <= AES_data_out;
                r_pt_out <= r_data_in;
            end
            r_done <= (r_state == S_DONE) && !abort;
        end
    end

    assign AES_data_in = r_data_in;
    assign AES_key_in  = r_key;
    assign ct_valid    = r_ct_valid;
    assign ct_out      = r_ct_out;
    assign pt_out      = r_pt_out;
    assign busy        = w_busy;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;
    assign traces_done = r_traces;

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Bench for aes_trace_sequencer: behavioural AES core stub, plaintext model
// built from the generation rules, one per-cycle compare process.
module tb_aes_trace_sequencer;
    localparam logic [127:0] CT_MASK  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [31:0]  SEED     = 32'hACE1_2468;
    localparam logic [127:0] M00_KEY  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    localparam logic [127:0] M00_PT   = 128'h00000056_00000000_00000000_00000000;

    logic         AES_clk = 1'b0;
    logic         AES_rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [127:0] base_pt = '0;
    logic [127:0] key = '0;
    logic [15:0]  trace_count = '0;
    logic [7:0]   gap_cycles = '0;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic         AES_data_out_valid;
    logic [127:0] AES_data_out;
    logic         ct_valid;
    logic [127:0] ct_out;
    logic [127:0] pt_out;
    logic         busy;
    logic         done;
    logic         timeout_err;
    logic [15:0]  traces_done;

    aes_trace_sequencer dut (
        .AES_clk(AES_clk), .AES_rst_n(AES_rst_n), .start(start), .abort(abort),
        .mode(mode), .base_pt(base_pt), .key(key), .trace_count(trace_count),
        .gap_cycles(gap_cycles), .AES_en(AES_en), .AES_data_in(AES_data_in),
        .AES_key_in(AES_key_in), .AES_data_out_valid(AES_data_out_valid),
        .AES_data_out(AES_data_out), .ct_valid(ct_valid), .ct_out(ct_out),
        .pt_out(pt_out), .busy(busy), .done(done), .timeout_err(timeout_err),
        .traces_done(traces_done)
    );

    always #5 AES_clk = ~AES_clk;

    // Behavioural core: answers core_lat cycles after it first sees AES_en
    int           core_lat = 10;
    logic         core_stall = 1'b0;
    logic         force_valid = 1'b0;
    int           core_cnt;
    logic         core_valid;
    logic [127:0] core_data;
    always @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            core_cnt <= 0; core_valid <= 1'b0; core_data <= '0;
        end else if (!AES_en) begin
            core_cnt <= 0; core_valid <= 1'b0;
        end else begin
            core_cnt   <= core_cnt + 1;
            core_valid <= !core_stall && (core_cnt == core_lat - 1);
            if (core_cnt == core_lat - 1) core_data <= AES_data_in ^ AES_key_in ^ CT_MASK;
        end
    end
    assign AES_data_out_valid = core_valid | force_valid;
    assign AES_data_out       = core_data;

    int n_total = 0;
    int n_pass  = 0;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Model state
    logic [127:0] en_q[$];
    logic [127:0] ct_q[$];
    int           cnt_q[$];
    logic [127:0] model_key;
    int           rise_cyc[$];
    logic [127:0] got_pt[$];
    int           cyc = 0;
    int           n_done = 0;
    int           last_ct_cyc = 0;
    int           last_en_len = 0;

    function automatic logic [31:0] galois(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic model_campaign(input logic [1:0] m, input logic [127:0] b,
                                  input logic [127:0] k, input int n);
        logic [31:0]  l;
        logic [127:0] p;
        l = SEED;
        en_q.delete(); ct_q.delete(); cnt_q.delete(); rise_cyc.delete(); got_pt.delete();
        model_key = k;
        for (int i = 0; i < n; i++) begin
            if (m == 2'b01) p = b + 128'(i);
            else if (m == 2'b10 || (m == 2'b11 && (i % 2) == 1)) begin
                p = b ^ {4{l}};
                l = galois(l);
            end else p = b;
            en_q.push_back(p);
            ct_q.push_back(p ^ k ^ CT_MASK);
            cnt_q.push_back(i + 1);
        end
    endtask

    initial forever begin
        @(posedge AES_clk);
        cyc++;
    end

    // Compare process: checks every core request and every returned result
    initial begin
        logic prev_en;
        int   en_len;
        prev_en = 1'b0;
        en_len  = 0;
        forever begin
            @(negedge AES_clk);
            if (AES_rst_n) begin
                if (AES_en) chk("en_implies_busy", 128'(busy), 128'd1);
                if (AES_en && !prev_en) begin
                    rise_cyc.push_back(cyc);
                    chk("en_expected", 128'(en_q.size() != 0), 128'd1);
                    if (en_q.size() != 0) begin
                        chk("en_pt", AES_data_in, en_q.pop_front());
                        chk("en_key", AES_key_in, model_key);
                    end
                end
                if (!AES_en && prev_en) last_en_len = en_len;
                en_len = AES_en ? en_len + 1 : 0;
                if (ct_valid) begin
                    got_pt.push_back(pt_out);
                    last_ct_cyc = cyc;
                    chk("ct_expected", 128'(ct_q.size() != 0), 128'd1);
                    if (ct_q.size() != 0) begin
                        chk("ct_ct", ct_out, ct_q.pop_front());
                        chk("ct_count", 128'(traces_done), 128'(cnt_q.pop_front()));
                    end
                end
                if (done) n_done++;
                prev_en = AES_en;
            end else begin
                prev_en = 1'b0;
                en_len  = 0;
            end
        end
    end

    task automatic nstep();
        @(negedge AES_clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [127:0] b, input logic [127:0] k,
                               input int n, input int g);
        @(posedge AES_clk); #1;
        mode = m; base_pt = b; key = k; trace_count = 16'(n); gap_cycles = 8'(g);
        start = 1'b1;
        @(posedge AES_clk); #1;
        start = 1'b0;
    endtask

    task automatic launch(input logic [1:0] m, input logic [127:0] b, input logic [127:0] k,
                          input int n, input int g);
        model_campaign(m, b, k, n);
        pulse_start(m, b, k, n, g);
    endtask

    task automatic wait_done(input int budget, input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            nstep();
            if (done) begin got = 1'b1; break; end
        end
        chk(name, 128'(got), 128'd1);
    endtask

    task automatic wait_ct(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (got_pt.size() < n && k < budget) begin nstep(); k++; end
        chk(name, 128'(got_pt.size() >= n), 128'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        // Reset state
        repeat (2) @(negedge AES_clk);
        chk("rst_en", 128'(AES_en), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_ctv", 128'(ct_valid), 128'd0);
        chk("rst_data_in", AES_data_in, 128'd0);
        chk("rst_key_in", AES_key_in, 128'd0);
        chk("rst_traces", 128'(traces_done), 128'd0);
        AES_rst_n = 1'b1;

        // Mode 00: fixed plaintext, gap 5, 51-cycle core
        core_lat = 51;
        d0 = n_done;
        launch(2'b00, M00_PT, M00_KEY, 3, 5);
        nstep();
        chk("m00_busy_load", 128'(busy), 128'd1);
        chk("m00_en_load", 128'(AES_en), 128'd0);
        nstep();
        chk("m00_en_run", 128'(AES_en), 128'd1);
        wait_done(400, "m00_done_seen");
        chk("m00_done_lat", 128'(cyc - last_ct_cyc), 128'd1);
        chk("m00_busy_at_done", 128'(busy), 128'd1);
        chk("m00_traces", 128'(traces_done), 128'd3);
        nstep();
        chk("m00_busy_fall", 128'(busy), 128'd0);
        chk("m00_period1", 128'(rise_cyc[1] - rise_cyc[0]), 128'd58);
        chk("m00_period2", 128'(rise_cyc[2] - rise_cyc[1]), 128'd58);
        for (int i = 0; i < 3; i++) chk("m00_pt_lit", got_pt[i], M00_PT);
        chk("m00_done_count", 128'(n_done - d0), 128'd1);
        chk("m00_ctq_empty", 128'(ct_q.size()), 128'd0);

        // Mode 01: increment wraps; start while busy and stray valid ignored
        core_lat = 10;
        d0 = n_done;
        launch(2'b01, {128{1'b1}}, 128'h1111, 2, 3);
        repeat (3) nstep();
        pulse_start(2'b00, 128'h0, 128'h0, 5, 0);
        wait_ct(1, 60, "m01_ct1_seen");
        @(posedge AES_clk); #1 force_valid = 1'b1;
        @(posedge AES_clk); #1 force_valid = 1'b0;
        wait_done(100, "m01_done_seen");
        chk("m01_pt0_lit", got_pt[0], {128{1'b1}});
        chk("m01_pt1_lit", got_pt[1], 128'd0);
        chk("m01_traces", 128'(traces_done), 128'd2);
        chk("m01_done_count", 128'(n_done - d0), 128'd1);
        chk("m01_ctq_empty", 128'(ct_q.size()), 128'd0);

        // Mode 11, gap 0: alternate fixed/random, back-to-back loads
        core_lat = 8;
        launch(2'b11, 128'd0, 128'h5555_0000, 4, 0);
        wait_done(200, "m11_done_seen");
        chk("m11_pt0_lit", got_pt[0], 128'd0);
        chk("m11_pt1_lit", got_pt[1], {4{32'hACE1_2468}});
        chk("m11_pt2_lit", got_pt[2], 128'd0);
        chk("m11_pt3_lit", got_pt[3], {4{32'h5670_9234}});
        chk("m11_b2b_period", 128'(rise_cyc[1] - rise_cyc[0]), 128'd10);
        chk("m11_traces", 128'(traces_done), 128'd4);

        // Timeout: core never answers
        core_stall = 1'b1;
        launch(2'b00, 128'h77, 128'h99, 2, 1);
        ct_q.delete(); cnt_q.delete();
        while (en_q.size() > 1) void'(en_q.pop_back());
        wait_done(200, "tmo_done_seen");
        chk("tmo_en_len", 128'(last_en_len), 128'd64);
        chk("tmo_err", 128'(timeout_err), 128'd1);
        chk("tmo_traces", 128'(traces_done), 128'd0);
        chk("tmo_rises", 128'(rise_cyc.size()), 128'd1);
        core_stall = 1'b0;
        launch(2'b00, 128'h77, 128'h99, 1, 0);
        nstep();
        chk("tmo_err_cleared", 128'(timeout_err), 128'd0);
        wait_done(100, "tmo_rerun_done");
        chk("tmo_rerun_traces", 128'(traces_done), 128'd1);

        // Abort during GAP
        core_lat = 5;
        d0 = n_done;
        launch(2'b00, 128'hAB, 128'hCD, 3, 20);
        wait_ct(1, 40, "abt_ct1_seen");
        @(posedge AES_clk); #1 abort = 1'b1;
        @(posedge AES_clk); #1 abort = 1'b0;
        nstep();
        chk("abt_busy", 128'(busy), 128'd0);
        repeat (30) nstep();
        chk("abt_no_done", 128'(n_done - d0), 128'd0);
        chk("abt_traces", 128'(traces_done), 128'd1);
        chk("abt_rises", 128'(rise_cyc.size()), 128'd1);
        en_q.delete(); ct_q.delete(); cnt_q.delete();

        // trace_count == 0
        launch(2'b10, 128'h1, 128'h2, 0, 0);
        wait_done(10, "zero_done_seen");
        chk("zero_no_en", 128'(rise_cyc.size()), 128'd0);
        chk("zero_traces", 128'(traces_done), 128'd0);

        // Asynchronous reset mid-RUN
        core_lat = 30;
        launch(2'b01, 128'h100, 128'h200, 3, 2);
        wait_ct(1, 60, "rst_ct1_seen");
        for (int i = 0; i < 20 && !AES_en; i++) nstep();
        chk("rst_mid_en_before", 128'(AES_en), 128'd1);
        #1 AES_rst_n = 1'b0;
        #1;
        chk("rst_mid_en", 128'(AES_en), 128'd0);
        chk("rst_mid_busy", 128'(busy), 128'd0);
        chk("rst_mid_ctout", ct_out, 128'd0);
        chk("rst_mid_ptout", pt_out, 128'd0);
        chk("rst_mid_data_in", AES_data_in, 128'd0);
        chk("rst_mid_traces", 128'(traces_done), 128'd0);
        repeat (2) @(negedge AES_clk);
        AES_rst_n = 1'b1;
        en_q.delete(); ct_q.delete(); cnt_q.delete();
        repeat (3) nstep();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
